// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared definitions for the multi-cycle MIPS control FSM.
// Holds the opcode values, the 4-bit state encoding and the datapath mux encodings.
package mc_ctrl_pkg;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_BNE   = 6'b000101;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_RTEXE,
        S_ALUWB, S_BEQ, S_JUMP, S_JAL, S_ADDIEXE, S_ADDIWB, S_BNE
    } state_t;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_4      = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;
endpackage

// File: rtl/mc_wait_timer.sv
// mc_wait_timer: counts consecutive stalled cycles of a bus access and flags a timeout.
// Ports: clk, rst_n (sync, active low), waiting (access pending and not ready this cycle),
//        timeout (combinational: this stalled cycle is the WAIT_MAX-th in a row).
// The count clears whenever the access is not stalling or has just timed out, so it
// restarts from zero for every new access.
module mc_wait_timer #(
    parameter int WAIT_MAX = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic waiting,
    output logic timeout
);
    localparam int W = WAIT_MAX > 1 ? $clog2(WAIT_MAX) : 1;
    logic [W-1:0] cnt;
    assign timeout = waiting && cnt == W'(WAIT_MAX - 1);
    always_ff @(posedge clk)
        cnt <= (!rst_n || !waiting || timeout) ? '0 : cnt + W'(1);
endmodule

// File: rtl/mc_control_fsm.sv
// mc_control_fsm: multi-cycle MIPS main control, a Moore FSM sequencing each instruction.
// Inputs : clk, rst_n (sync, active low), opcode (IR[31:26]), mem_ready (access done).
// Outputs: datapath strobes/mux selects, illegal_op / mem_timeout / instr_done pulses,
//          retired_cnt (wrapping count of retired instructions).
// Optional: define CTRL_BNE_EN to add the bne state and the branch_ne output.
module mc_control_fsm
    import mc_ctrl_pkg::*;
#(
    parameter int WAIT_MAX = 8,
    parameter int CNT_W    = 16,
    parameter int ALUOP_W  = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [5:0]         opcode,
    input  logic               mem_ready,
    output logic               pc_write,
    output logic               pc_write_cond,
    output logic               i_or_d,
    output logic               mem_read,
    output logic               mem_write,
    output logic               ir_write,
    output logic               reg_dst,
    output logic               mem_to_reg,
    output logic               reg_write,
    output logic               jal,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [ALUOP_W-1:0] alu_op,
    output logic [1:0]         pc_source,
    output logic               illegal_op,
    output logic               mem_timeout,
    output logic               instr_done,
    output logic [CNT_W-1:0]   retired_cnt
`ifdef CTRL_BNE_EN
    ,
    output logic               branch_ne
`endif
);
    state_t state, nxt;
    logic   mem_state, timeout;

    assign mem_state = state == S_FETCH || state == S_MEMRD || state == S_MEMWR;

    mc_wait_timer #(.WAIT_MAX(WAIT_MAX)) u_wait (
        .clk(clk),
        .rst_n(rst_n),
        .waiting(rst_n && mem_state && !mem_ready),
        .timeout(timeout)
    );

    always_ff @(posedge clk) begin
        state       <= rst_n ? nxt : S_FETCH;
        retired_cnt <= rst_n ? retired_cnt + CNT_W'(instr_done) : '0;
    end

    // Everything, including the FETCH strobes, stays low while reset is held.
    always_comb begin
        nxt           = state;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        jal           = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = SRCB_B;
        alu_op        = ALUOP_W'(ALU_ADD);
        pc_source     = PCSRC_ALU;
        illegal_op    = 1'b0;
        mem_timeout   = 1'b0;
        instr_done    = 1'b0;
`ifdef CTRL_BNE_EN
        branch_ne     = 1'b0;
`endif
        if (rst_n) begin
            case (state)
                S_FETCH: begin
                    mem_read    = 1'b1;
                    alu_src_b   = SRCB_4;
                    ir_write    = mem_ready;
                    pc_write    = mem_ready;
                    mem_timeout = timeout;
                    nxt         = mem_ready ? S_DECODE : S_FETCH;
                end
                S_DECODE: begin
                    alu_src_b = SRCB_IMM_SH;
                    case (opcode)
                        OP_LW, OP_SW: nxt = S_MEMADR;
                        OP_RTYPE:     nxt = S_RTEXE;
                        OP_BEQ:       nxt = S_BEQ;
                        OP_J:         nxt = S_JUMP;
                        OP_JAL:       nxt = S_JAL;
                        OP_ADDI:      nxt = S_ADDIEXE;
`ifdef CTRL_BNE_EN
                        OP_BNE:       nxt = S_BNE;
`endif
                        default: begin
                            nxt        = S_FETCH;
                            illegal_op = 1'b1;
                        end
                    endcase
                end
                S_MEMADR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = SRCB_IMM;
                    nxt       = opcode == OP_SW ? S_MEMWR : S_MEMRD;
                end
                S_MEMRD: begin
                    mem_read    = 1'b1;
                    i_or_d      = 1'b1;
                    mem_timeout = timeout;
                    nxt         = mem_ready ? S_MEMWB : S_MEMRD;
                end
                S_MEMWB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                    instr_done = 1'b1;
                end
                S_MEMWR: begin
                    mem_write   = !timeout;
                    i_or_d      = 1'b1;
                    mem_timeout = timeout;
                    instr_done  = mem_ready;
                    nxt         = mem_ready ? S_FETCH : S_MEMWR;
                end
                S_RTEXE: begin
                    alu_src_a = 1'b1;
                    alu_op    = ALUOP_W'(ALU_FUNCT);
                    nxt       = S_ALUWB;
                end
                S_ALUWB: begin
                    reg_write  = 1'b1;
                    reg_dst    = 1'b1;
                    instr_done = 1'b1;
                end
                S_BEQ: begin
                    alu_src_a     = 1'b1;
                    alu_op        = ALUOP_W'(ALU_SUB);
                    pc_write_cond = 1'b1;
                    pc_source     = PCSRC_ALUOUT;
                    instr_done    = 1'b1;
                end
                S_JUMP: begin
                    pc_write   = 1'b1;
                    pc_source  = PCSRC_JUMP;
                    instr_done = 1'b1;
                end
                S_JAL: begin
                    pc_write   = 1'b1;
                    pc_source  = PCSRC_JUMP;
                    reg_write  = 1'b1;
                    jal        = 1'b1;
                    instr_done = 1'b1;
                end
                S_ADDIEXE: begin
                    alu_src_a = 1'b1;
                    alu_src_b = SRCB_IMM;
                    nxt       = S_ADDIWB;
                end
                S_ADDIWB: begin
                    reg_write  = 1'b1;
                    instr_done = 1'b1;
                end
`ifdef CTRL_BNE_EN
                S_BNE: begin
                    alu_src_a     = 1'b1;
                    alu_op        = ALUOP_W'(ALU_SUB);
                    pc_write_cond = 1'b1;
                    pc_source     = PCSRC_ALUOUT;
                    branch_ne     = 1'b1;
                    instr_done    = 1'b1;
                end
`endif
                default: nxt = S_FETCH;
            endcase
            // Every retiring state returns to FETCH; timeouts abort to FETCH too.
            if (instr_done || mem_timeout)
                nxt = S_FETCH;
        end
    end
endmodule

// File: tb/tb_mc_control_fsm.sv
// tb_mc_control_fsm: randomized + directed check of mc_control_fsm against an
// instruction-level model (instruction class, step within it, stall count).
module tb_mc_control_fsm;
    localparam int WAIT_MAX = 8;
    localparam int CNT_W    = 2;

    typedef struct packed {
        logic pcw, pcwc, iord, mr, mw, irw, rdst, m2r, rw, jl, asa;
        logic [1:0] asb, aop, psrc;
        logic ill, to, done;
    } ctl_t;

    logic clk = 1'b0, rst_n = 1'b0, mem_ready = 1'b0;
    logic [5:0] opcode = 6'd0;
    logic pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, reg_dst;
    logic mem_to_reg, reg_write, jal, alu_src_a, illegal_op, mem_timeout, instr_done;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic [CNT_W-1:0] retired_cnt;
    logic bne_out;
    ctl_t got;

    int vectors = 0, miscompares = 0;
    int step = 0, wt = 0, cnt = 0, stuck = 0;
    logic [5:0] mop = 6'd0;

    always #5 clk = ~clk;

    mc_control_fsm #(.WAIT_MAX(WAIT_MAX), .CNT_W(CNT_W), .ALUOP_W(2)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write), .jal(jal),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .pc_source(pc_source), .illegal_op(illegal_op), .mem_timeout(mem_timeout),
        .instr_done(instr_done), .retired_cnt(retired_cnt)
`ifdef CTRL_BNE_EN
        , .branch_ne(bne_out)
`endif
    );
`ifndef CTRL_BNE_EN
    assign bne_out = 1'b0;
`endif

    assign got = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, reg_dst,
                  mem_to_reg, reg_write, jal, alu_src_a, alu_src_b, alu_op, pc_source,
                  illegal_op, mem_timeout, instr_done};

`ifdef CTRL_BNE_EN
    localparam bit BNE_ON = 1'b1;
`else
    localparam bit BNE_ON = 1'b0;
`endif

    function automatic bit is_legal(input logic [5:0] o);
        return o == 6'd0 || o == 6'd35 || o == 6'd43 || o == 6'd4 || o == 6'd2 ||
               o == 6'd3 || o == 6'd8 || (BNE_ON && o == 6'd5);
    endfunction

    // Cycles each instruction class takes with zero-wait memory.
    function automatic int ilen(input logic [5:0] o);
        return o == 6'd35 ? 5 : (o == 6'd0 || o == 6'd8 || o == 6'd43) ? 4 : 3;
    endfunction

    task automatic lit(input string nm, input logic [31:0] g, input logic [31:0] w);
        vectors++;
        if (g !== w) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, g, w, $time);
        end
    endtask

    task automatic cyc(input logic r, input logic rdy, input logic [5:0] op);
        ctl_t e;
        logic ebne;
        bit memst, stall, to;
        @(negedge clk);
        rst_n = r;
        mem_ready = rdy;
        opcode = op;
        #1;
        if (step == 1) mop = op;
        e = '0;
        ebne = 1'b0;
        memst = r && (step == 0 || (step == 3 && (mop == 6'd35 || mop == 6'd43)));
        stall = memst && !rdy;
        to = stall && wt == WAIT_MAX - 1;
        if (r) begin
            e.to = to;
            if (step == 0) begin
                e.mr = 1; e.asb = 2'd1; e.irw = rdy; e.pcw = rdy;
            end else if (step == 1) begin
                e.asb = 2'd3; e.ill = !is_legal(mop);
            end else if (step == 2) begin
                if (mop == 6'd35 || mop == 6'd43 || mop == 6'd8) begin
                    e.asa = 1; e.asb = 2'd2;
                end else if (mop == 6'd0) begin
                    e.asa = 1; e.aop = 2'd2;
                end else if (mop == 6'd4 || mop == 6'd5) begin
                    e.asa = 1; e.aop = 2'd1; e.pcwc = 1; e.psrc = 2'd1; e.done = 1;
                    ebne = mop == 6'd5;
                end else begin
                    e.pcw = 1; e.psrc = 2'd2; e.done = 1;
                    e.rw = mop == 6'd3; e.jl = mop == 6'd3;
                end
            end else if (step == 3) begin
                if (mop == 6'd35) begin
                    e.mr = 1; e.iord = 1;
                end else if (mop == 6'd43) begin
                    e.mw = !to; e.iord = 1; e.done = rdy;
                end else begin
                    e.rw = 1; e.rdst = mop == 6'd0; e.done = 1;
                end
            end else begin
                e.rw = 1; e.m2r = 1; e.done = 1;
            end
        end
        vectors++;
        if (got !== e) begin
            miscompares++;
            $display("FAIL ctl: got %05h expected %05h (step %0d op %0d) at %0t", got, e, step, mop, $time);
        end
        vectors++;
        if (retired_cnt !== CNT_W'(cnt)) begin
            miscompares++;
            $display("FAIL retired_cnt: got %0d expected %0d at %0t", retired_cnt, cnt, $time);
        end
        vectors++;
        if (bne_out !== ebne) begin
            miscompares++;
            $display("FAIL branch_ne: got %0b expected %0b at %0t", bne_out, ebne, $time);
        end
        if (!r) begin
            step = 0; wt = 0; cnt = 0;
        end else begin
            if (to) begin
                step = 0; wt = 0;
            end else if (stall) begin
                wt++;
            end else begin
                wt = 0;
                step = (step == 1 && !is_legal(mop)) || step == ilen(mop) - 1 ? 0 : step + 1;
            end
            cnt = (cnt + int'(e.done)) % (1 << CNT_W);
        end
    endtask

    initial begin
        logic [5:0] ops [10];
        logic [5:0] o;
        ops = '{6'd0, 6'd35, 6'd43, 6'd4, 6'd2, 6'd3, 6'd8, 6'd5, 6'd63, 6'd17};
        repeat (2) @(posedge clk);
        cyc(0, 1, 0);
        lit("reset_mem_read", 32'(mem_read), 0);
        lit("reset_all_zero", 32'(got), 0);
        lit("reset_cnt", 32'(retired_cnt), 0);
        // R-type, zero-wait
        repeat (3) cyc(1, 1, 0);
        cyc(1, 1, 0);
        lit("r_reg_write", 32'(reg_write), 1);
        lit("r_reg_dst", 32'(reg_dst), 1);
        lit("r_done", 32'(instr_done), 1);
        // lw with three stalled MEMRD cycles
        cyc(1, 1, 35);
        lit("r_cnt", 32'(retired_cnt), 1);
        repeat (2) cyc(1, 1, 35);
        repeat (3) begin
            cyc(1, 0, 35);
            lit("lw_mem_read", 32'(mem_read), 1);
            lit("lw_no_timeout", 32'(mem_timeout), 0);
        end
        cyc(1, 1, 35);
        cyc(1, 1, 35);
        lit("lw_mem_to_reg", 32'(mem_to_reg), 1);
        lit("lw_reg_write", 32'(reg_write), 1);
        // FETCH stuck until timeout
        repeat (7) begin
            cyc(1, 0, 0);
            lit("to_ir_write", 32'(ir_write), 0);
        end
        cyc(1, 0, 0);
        lit("to_pulse", 32'(mem_timeout), 1);
        lit("to_ir_write_last", 32'(ir_write), 0);
        cyc(1, 1, 63);
        lit("to_cnt_kept", 32'(retired_cnt), 2);
        lit("refetch_ir_write", 32'(ir_write), 1);
        cyc(1, 1, 63);
        lit("illegal_pulse", 32'(illegal_op), 1);
        lit("illegal_no_rw", 32'(reg_write), 0);
        cyc(1, 1, 3);
        lit("illegal_back_fetch", 32'(mem_read), 1);
        // jal
        cyc(1, 1, 3);
        cyc(1, 1, 3);
        lit("jal_pc_write", 32'(pc_write), 1);
        lit("jal_pc_source", 32'(pc_source), 2);
        lit("jal_jal", 32'(jal), 1);
        lit("jal_reg_write", 32'(reg_write), 1);
        // jump wraps the 2-bit counter from 3 to 0
        repeat (3) cyc(1, 1, 2);
        lit("j_cnt_before", 32'(retired_cnt), 3);
        cyc(1, 1, 43);
        lit("wrap_cnt", 32'(retired_cnt), 0);
        // sw, then reset in MEMWR
        repeat (2) cyc(1, 1, 43);
        cyc(1, 0, 43);
        lit("sw_mem_write", 32'(mem_write), 1);
        cyc(0, 0, 43);
        lit("rst_all_zero", 32'(got), 0);
        cyc(0, 1, 0);
        lit("rst_cnt", 32'(retired_cnt), 0);
        // opcode 000101
        cyc(1, 1, 5);
        cyc(1, 1, 5);
        lit("bne_decode_illegal", 32'(illegal_op), 32'(!BNE_ON));
`ifdef CTRL_BNE_EN
        cyc(1, 1, 5);
        lit("bne_branch_ne", 32'(bne_out), 1);
        lit("bne_pc_write_cond", 32'(pc_write_cond), 1);
`endif
        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            logic rdy, r;
            o = step == 0 ? ($urandom_range(0, 9) == 9 ? 6'($urandom) : ops[$urandom_range(0, 8)]) : opcode;
            if (stuck > 0) begin
                rdy = 1'b0;
                stuck--;
            end else begin
                if ($urandom_range(0, 39) == 0) stuck = $urandom_range(3, 12);
                rdy = $urandom_range(0, 3) != 0;
            end
            r = $urandom_range(0, 99) != 0;
            cyc(r, rdy, o);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
